// File: rtl/memory_stage_if.sv
// Signal bundle between the execute/hazard side and the Y86-64 memory stage.
// Field names follow the pipeline register naming (e_*, M_*, m_*, W_*).
interface memory_stage_if;
    logic        M_stall;
    logic        M_bubble;
    logic        W_stall;
    logic [3:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_destE;
    logic [3:0]  e_destM;

    logic [3:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_destE;
    logic [3:0]  M_destM;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic [3:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_destE;
    logic [3:0]  W_destM;

    modport master (
        output M_stall, M_bubble, W_stall, e_stat, e_icode, e_cnd,
               e_valE, e_valA, e_destE, e_destM,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_destE, M_destM,
               m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_destE, W_destM
    );

    modport slave (
        input  M_stall, M_bubble, W_stall, e_stat, e_icode, e_cnd,
               e_valE, e_valA, e_destE, e_destM,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_destE, M_destM,
               m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_destE, W_destM
    );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, byte-addressed little-endian data
// memory, and the W pipeline register feeding writeback/forwarding.
module memory_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic               clk,
    input  logic               rst,
    memory_stage_if.slave      bus
);
    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  destE;
        logic [3:0]  destM;
    } m_reg_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  destE;
        logic [3:0]  destM;
    } w_reg_t;

    localparam m_reg_t M_BUBBLE = '{stat: SAOK, icode: I_NOP, cnd: 1'b0,
                                    valE: 64'd0, valA: 64'd0,
                                    destE: RNONE, destM: RNONE};
    localparam w_reg_t W_BUBBLE = '{stat: SAOK, icode: I_NOP,
                                    valE: 64'd0, valM: 64'd0,
                                    destE: RNONE, destM: RNONE};

    m_reg_t            r_m;
    w_reg_t            r_w;
    logic [7:0]        r_mem [MEM_BYTES];

    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  w_idx;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic              w_adr_err;
    logic              w_mem_we;
    logic [63:0]       w_rd_data;
    logic [63:0]       w_valM;
    logic [3:0]        w_stat;

    always_comb begin
        w_mem_rd = 1'b0;
        w_mem_wr = 1'b0;
        w_addr   = '0;
        unique case (r_m.icode)
            I_RMMOVQ, I_PUSHQ, I_CALL: begin w_mem_wr = 1'b1; w_addr = r_m.valE; end
            I_MRMOVQ:                  begin w_mem_rd = 1'b1; w_addr = r_m.valE; end
            I_POPQ, I_RET:             begin w_mem_rd = 1'b1; w_addr = r_m.valA; end
            default: ;
        endcase
    end

    // The compare on the full address also catches wrap-around near 2^64.
    assign w_adr_err = (w_mem_rd || w_mem_wr) && (w_addr > MAX_ADDR);
    assign w_idx     = w_addr[IDX_W-1:0];
    assign w_stat    = w_adr_err ? SADR : r_m.stat;
    assign w_mem_we  = w_mem_wr && !w_adr_err && (r_m.stat == SAOK) &&
                       (r_w.stat == SAOK) && !bus.M_stall && !rst;

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < 8; k++)
            w_rd_data[8*k +: 8] = r_mem[w_idx + IDX_W'(k)];
    end

    assign w_valM = (w_mem_rd && !w_adr_err) ? w_rd_data : 64'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= M_BUBBLE;
        end else if (bus.M_stall) begin
            r_m <= r_m;
        end else if (bus.M_bubble) begin
            r_m <= M_BUBBLE;
        end else begin
            r_m.stat  <= bus.e_stat;
            r_m.icode <= bus.e_icode;
            r_m.cnd   <= bus.e_cnd;
            r_m.valE  <= bus.e_valE;
            r_m.valA  <= bus.e_valA;
            r_m.destE <= (bus.e_icode == I_RRMOVQ && !bus.e_cnd) ? RNONE : bus.e_destE;
            r_m.destM <= bus.e_destM;
        end
    end

    // NOTE: memory is cleared on reset here, which forces a flop array rather
    // than an SRAM macro; that is the architectural behaviour this stage needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++)
                r_mem[i] <= 8'h00;
        end else if (w_mem_we) begin
            for (int k = 0; k < 8; k++)
                r_mem[w_idx + IDX_W'(k)] <= r_m.valA[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w <= W_BUBBLE;
        end else if (!bus.W_stall) begin
            r_w.stat  <= w_stat;
            r_w.icode <= r_m.icode;
            r_w.valE  <= r_m.valE;
            r_w.valM  <= w_valM;
            r_w.destE <= r_m.destE;
            r_w.destM <= r_m.destM;
        end
    end

    assign bus.M_stat  = r_m.stat;
    assign bus.M_icode = r_m.icode;
    assign bus.M_cnd   = r_m.cnd;
    assign bus.M_valE  = r_m.valE;
    assign bus.M_valA  = r_m.valA;
    assign bus.M_destE = r_m.destE;
    assign bus.M_destM = r_m.destM;
    assign bus.m_valM  = w_valM;
    assign bus.m_stat  = w_stat;
    assign bus.W_stat  = r_w.stat;
    assign bus.W_icode = r_w.icode;
    assign bus.W_valE  = r_w.valE;
    assign bus.W_valM  = r_w.valM;
    assign bus.W_destE = r_w.destE;
    assign bus.W_destM = r_w.destM;
endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage with hand-computed expectations.
module tb_memory_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    memory_stage_if bus ();

    memory_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] icode, input logic cnd,
                         input logic [63:0] vale, input logic [63:0] vala,
                         input logic [3:0] deste, input logic [3:0] destm);
        bus.e_stat  = 4'h1;
        bus.e_icode = icode;
        bus.e_cnd   = cnd;
        bus.e_valE  = vale;
        bus.e_valA  = vala;
        bus.e_destE = deste;
        bus.e_destM = destm;
    endtask

    task automatic nop;
        drive(4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    task automatic test_reset;
        bus.M_stall = 1'b0; bus.M_bubble = 1'b0; bus.W_stall = 1'b0;
        rst = 1'b1;
        drive(4'h4, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 4'h3);
        tick; tick;
        checks++; if (bus.M_icode !== 4'h1) begin errors++; $display("FAIL reset_M_icode got %h want 1", bus.M_icode); end
        checks++; if (bus.M_stat !== 4'h1) begin errors++; $display("FAIL reset_M_stat got %h want 1", bus.M_stat); end
        checks++; if (bus.M_destE !== 4'hF) begin errors++; $display("FAIL reset_M_destE got %h want F", bus.M_destE); end
        checks++; if (bus.W_icode !== 4'h1) begin errors++; $display("FAIL reset_W_icode got %h want 1", bus.W_icode); end
        checks++; if (bus.W_stat !== 4'h1) begin errors++; $display("FAIL reset_W_stat got %h want 1", bus.W_stat); end
        checks++; if (bus.m_valM !== 64'd0) begin errors++; $display("FAIL reset_m_valM got %h want 0", bus.m_valM); end
        checks++; if (dut.r_mem[0] !== 8'h00) begin errors++; $display("FAIL reset_mem0 got %h want 00", dut.r_mem[0]); end
        rst = 1'b0;
        nop;
        tick;
    endtask

    task automatic test_store_load;
        drive(4'h4, 1'b1, 64'h40, 64'h1122_3344_5566_7788, 4'hF, 4'hF);
        tick;
        drive(4'h5, 1'b1, 64'h40, 64'h0, 4'hF, 4'h3);
        tick;
        checks++; if (bus.m_valM !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL load_m_valM got %h want 1122334455667788", bus.m_valM); end
        checks++; if (bus.m_stat !== 4'h1) begin errors++; $display("FAIL load_m_stat got %h want 1", bus.m_stat); end
        checks++; if (dut.r_mem[64] !== 8'h88) begin errors++; $display("FAIL store_byte40 got %h want 88", dut.r_mem[64]); end
        checks++; if (dut.r_mem[71] !== 8'h11) begin errors++; $display("FAIL store_byte47 got %h want 11", dut.r_mem[71]); end
        nop;
        tick;
        checks++; if (bus.W_valM !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL load_W_valM got %h want 1122334455667788", bus.W_valM); end
        checks++; if (bus.W_icode !== 4'h5) begin errors++; $display("FAIL load_W_icode got %h want 5", bus.W_icode); end
        checks++; if (bus.W_destM !== 4'h3) begin errors++; $display("FAIL load_W_destM got %h want 3", bus.W_destM); end
    endtask

    task automatic test_bad_addr;
        drive(4'hA, 1'b1, 64'd1020, 64'hDEAD, 4'h4, 4'hF);
        tick;
        checks++; if (bus.m_stat !== 4'h3) begin errors++; $display("FAIL push_bad_m_stat got %h want 3", bus.m_stat); end
        drive(4'h4, 1'b1, 64'h10, 64'h5555, 4'hF, 4'hF);
        tick;
        checks++; if (bus.W_stat !== 4'h3) begin errors++; $display("FAIL push_bad_W_stat got %h want 3", bus.W_stat); end
        checks++; if (dut.r_mem[1020] !== 8'h00) begin errors++; $display("FAIL push_bad_mem got %h want 00", dut.r_mem[1020]); end
        drive(4'h5, 1'b1, 64'h10, 64'h0, 4'hF, 4'h1);
        tick;
        checks++; if (bus.m_valM !== 64'd0) begin errors++; $display("FAIL suppressed_store got %h want 0", bus.m_valM); end
        drive(4'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'hF, 4'h1);
        tick;
        checks++; if (bus.m_stat !== 4'h3) begin errors++; $display("FAIL wrap_m_stat got %h want 3", bus.m_stat); end
        checks++; if (bus.m_valM !== 64'd0) begin errors++; $display("FAIL wrap_m_valM got %h want 0", bus.m_valM); end
        drive(4'h5, 1'b1, 64'd1016, 64'h0, 4'hF, 4'h1);
        tick;
        checks++; if (bus.m_stat !== 4'h1) begin errors++; $display("FAIL edge1016_m_stat got %h want 1", bus.m_stat); end
        drive(4'h5, 1'b1, 64'd1017, 64'h0, 4'hF, 4'h1);
        tick;
        checks++; if (bus.m_stat !== 4'h3) begin errors++; $display("FAIL edge1017_m_stat got %h want 3", bus.m_stat); end
        nop;
        tick; tick;
    endtask

    task automatic test_cmov;
        drive(4'h2, 1'b0, 64'h7, 64'h7, 4'h3, 4'hF);
        tick;
        checks++; if (bus.M_destE !== 4'hF) begin errors++; $display("FAIL cmov_nt_destE got %h want F", bus.M_destE); end
        drive(4'h2, 1'b1, 64'h77, 64'h77, 4'h3, 4'hF);
        tick;
        checks++; if (bus.M_destE !== 4'h3) begin errors++; $display("FAIL cmov_t_destE got %h want 3", bus.M_destE); end
        nop;
        tick;
        checks++; if (bus.W_valE !== 64'h77) begin errors++; $display("FAIL cmov_W_valE got %h want 77", bus.W_valE); end
        checks++; if (bus.W_destE !== 4'h3) begin errors++; $display("FAIL cmov_W_destE got %h want 3", bus.W_destE); end
    endtask

    task automatic test_stall_bubble;
        drive(4'h4, 1'b1, 64'h80, 64'hCAFE, 4'hF, 4'hF);
        tick;
        bus.M_stall = 1'b1;
        drive(4'h5, 1'b1, 64'h88, 64'h0, 4'hF, 4'h2);
        tick;
        checks++; if (bus.M_icode !== 4'h4) begin errors++; $display("FAIL mstall_icode got %h want 4", bus.M_icode); end
        checks++; if (bus.M_valE !== 64'h80) begin errors++; $display("FAIL mstall_valE got %h want 80", bus.M_valE); end
        checks++; if (dut.r_mem[128] !== 8'h00) begin errors++; $display("FAIL mstall_nowrite got %h want 00", dut.r_mem[128]); end
        bus.M_stall = 1'b0;
        drive(4'h5, 1'b1, 64'h80, 64'h0, 4'hF, 4'h2);
        tick;
        checks++; if (bus.m_valM !== 64'hCAFE) begin errors++; $display("FAIL after_stall_load got %h want CAFE", bus.m_valM); end
        bus.M_bubble = 1'b1;
        drive(4'h4, 1'b1, 64'h200, 64'h99, 4'h6, 4'h6);
        tick;
        checks++; if (bus.M_icode !== 4'h1) begin errors++; $display("FAIL mbubble_icode got %h want 1", bus.M_icode); end
        checks++; if (bus.M_destE !== 4'hF) begin errors++; $display("FAIL mbubble_destE got %h want F", bus.M_destE); end
        bus.M_bubble = 1'b0;
        drive(4'h2, 1'b1, 64'h9, 64'h9, 4'h5, 4'hF);
        tick;
        bus.M_stall = 1'b1; bus.M_bubble = 1'b1;
        drive(4'h5, 1'b1, 64'h300, 64'h0, 4'hF, 4'h1);
        tick;
        checks++; if (bus.M_icode !== 4'h2) begin errors++; $display("FAIL stall_bubble_icode got %h want 2", bus.M_icode); end
        checks++; if (bus.M_valE !== 64'h9) begin errors++; $display("FAIL stall_bubble_valE got %h want 9", bus.M_valE); end
        checks++; if (bus.W_icode !== 4'h2) begin errors++; $display("FAIL w_load_icode got %h want 2", bus.W_icode); end
        bus.M_stall = 1'b0; bus.M_bubble = 1'b0; bus.W_stall = 1'b1;
        nop;
        tick;
        checks++; if (bus.W_icode !== 4'h2) begin errors++; $display("FAIL wstall_icode got %h want 2", bus.W_icode); end
        checks++; if (bus.W_valE !== 64'h9) begin errors++; $display("FAIL wstall_valE got %h want 9", bus.W_valE); end
        checks++; if (bus.W_destE !== 4'h5) begin errors++; $display("FAIL wstall_destE got %h want 5", bus.W_destE); end
        bus.W_stall = 1'b0;
        tick;
    endtask

    task automatic test_pop_ret;
        drive(4'h4, 1'b1, 64'h100, 64'hABCD, 4'hF, 4'hF);
        tick;
        drive(4'hB, 1'b1, 64'h108, 64'h100, 4'h4, 4'h5);
        tick;
        checks++; if (bus.m_valM !== 64'hABCD) begin errors++; $display("FAIL popq_m_valM got %h want ABCD", bus.m_valM); end
        drive(4'h9, 1'b1, 64'h108, 64'h100, 4'h4, 4'hF);
        tick;
        checks++; if (bus.W_valE !== 64'h108) begin errors++; $display("FAIL popq_W_valE got %h want 108", bus.W_valE); end
        checks++; if (bus.W_valM !== 64'hABCD) begin errors++; $display("FAIL popq_W_valM got %h want ABCD", bus.W_valM); end
        checks++; if (bus.m_valM !== 64'hABCD) begin errors++; $display("FAIL ret_m_valM got %h want ABCD", bus.m_valM); end
        drive(4'h4, 1'b1, 64'h100, 64'h1234, 4'hF, 4'hF);
        tick;
        rst = 1'b1;
        nop;
        tick;
        checks++; if (bus.W_icode !== 4'h1) begin errors++; $display("FAIL rst_W_icode got %h want 1", bus.W_icode); end
        checks++; if (bus.W_valE !== 64'd0) begin errors++; $display("FAIL rst_W_valE got %h want 0", bus.W_valE); end
        checks++; if (bus.W_valM !== 64'd0) begin errors++; $display("FAIL rst_W_valM got %h want 0", bus.W_valM); end
        checks++; if (bus.W_destE !== 4'hF) begin errors++; $display("FAIL rst_W_destE got %h want F", bus.W_destE); end
        checks++; if (dut.r_mem[256] !== 8'h00) begin errors++; $display("FAIL rst_nowrite got %h want 00", dut.r_mem[256]); end
        rst = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_bad_addr;
        test_cmov;
        test_stall_bubble;
        test_pop_ret;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 pipeline memory stage. It sits directly downstream of the execute stage.
- Contains the M pipeline register, which latches the e_* outputs of execute.
- Contains a byte-addressed, 64-bit little-endian data memory.
- Contains the W pipeline register, which feeds writeback and forwarding.
- Produces m_valM and m_stat combinationally from the M register contents.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes.
- ADDR_W, 64: address width. Addresses use the full 64-bit valE/valA.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- M_stall  in  1  hold the M register
- M_bubble  in  1  load a NOP into the M register
- W_stall  in  1  hold the W register
- e_stat  in  4  execute status
- e_icode  in  4  execute icode
- e_cnd  in  1  condition result
- e_valE  in  64  ALU result
- e_valA  in  64  store data / stack pointer
- e_destE  in  4  destination register E
- e_destM  in  4  destination register M
- M_stat, M_icode  out  4 each  M register fields
- M_cnd  out  1  M register field
- M_valE, M_valA  out  64 each  M register fields
- M_destE, M_destM  out  4 each  M register fields
- m_valM  out  64  memory read data (combinational)
- m_stat  out  4  stage status (combinational)
- W_stat, W_icode  out  4 each  W register fields
- W_valE, W_valM  out  64 each  W register fields
- W_destE, W_destM  out  4 each  W register fields

Behaviour:
- Encodings:
  - Status: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - RNONE = 4'hF; NOP icode = 1.
  - Icodes: rrmovq/cmov=2, rmmovq=4, mrmovq=5, call=8, ret=9, pushq=A, popq=B.
- Bubble value (M and W registers):
  - stat=SAOK, icode=1, cnd=0.
  - All vals=0, destE=destM=RNONE.
- Reset: at a rising edge with rst=1, the M and W registers take the bubble value and all memory bytes clear to 0. rst overrides stall and bubble. A reset during a store suppresses that store.
- M register update, each rising edge, priority rst > M_stall > M_bubble > load:
  - Load copies the e_* inputs into the M register.
  - Conditional move not taken: if e_icode=2 and e_cnd=0, load M_destE=RNONE.
  - M_stall and M_bubble asserted together: stall wins.
- Memory address, from M register fields:
  - rmmovq, pushq, call, mrmovq: address = M_valE.
  - popq, ret: address = M_valA.
  - Any other icode: no memory access.
- Memory read:
  - Reads occur for mrmovq, popq and ret.
  - m_valM = 8 bytes at address..address+7, little-endian, combinational, in the same cycle.
  - When there is no read, or the address is invalid, m_valM = 0.
- Memory write:
  - Writes occur for rmmovq, pushq and call.
  - Write data = M_valA, written little-endian at the rising edge that ends the M cycle.
  - The write is suppressed if the address is invalid, M_stat≠SAOK, W_stat≠SAOK, or M_stall=1.
- Address error: an access is invalid if address > MEM_BYTES-8 (unsigned). This covers wrap-around, e.g. 64'hFFFF_FFFF_FFFF_FFFC.
- m_stat = SADR if the access is invalid, otherwise M_stat.
- Read-after-write: a read in the cycle after a write to an overlapping address returns the new data. Memory is a register array; there is no read-during-write bypass within the same cycle.
- W register update, each rising edge, priority rst > W_stall > load:
  - Load takes W_stat←m_stat, W_icode←M_icode, W_valE←M_valE, W_valM←m_valM, W_destE←M_destE, W_destM←M_destM.
- Latency: e_* input to W outputs is 2 clocks with no stalls.

Test Plan:
- Reset, then check outputs: M_icode=1, M_stat=1, M_destE=F, W_icode=1, m_valM=0.
- Store then load: rmmovq with e_valE=0x40, e_valA=0x1122334455667788, followed by mrmovq with e_valE=0x40 → m_valM=0x1122334455667788 in mrmovq's M cycle; W_valM shows the same value one cycle later; byte 0x40 = 0x88.
- Bad address: pushq with e_valE=MEM_BYTES-4 → m_stat=3 and no memory change. A following rmmovq to 0x10 is also suppressed because W_stat=3; reading 0x10 returns 0.
- Conditional move not taken: e_icode=2, e_cnd=0, e_destE=3 → M_destE=F. With e_cnd=1 → M_destE=3.
- Stall and bubble:
  - M_stall=1 with changing e_* inputs → M fields unchanged and a pending rmmovq is not rewritten.
  - M_bubble=1 → M_icode=1 next cycle.
  - M_stall=1 and M_bubble=1 together → hold.
  - W_stall=1 → W fields hold.
- popq and ret read from M_valA: after storing 0xABCD at 0x100, popq with e_valA=0x100 and e_valE=0x108 → m_valM=0xABCD and W_valE=0x108. Asserting rst in that cycle → W registers take the bubble value and no write occurs.
